// File: rtl/alu_mod_if.sv
// Operand/opcode request and registered result/flag bundle for alu_mod.
// The master side drives the request; the slave side (the ALU) returns the result.
interface alu_mod_if #(
    parameter int DATA_W = 8,
    parameter int OP_W   = 6
);
    logic              i_valid;
    logic [OP_W-1:0]   i_opcode;
    logic [DATA_W-1:0] i_ope1;
    logic [DATA_W-1:0] i_ope2;
    logic [DATA_W-1:0] o_result;
    logic              o_valid;
    logic              o_zero;
    logic              o_carry;
    logic              o_overflow;
    logic              o_err;

    modport master (
        output i_valid, i_opcode, i_ope1, i_ope2,
        input  o_result, o_valid, o_zero, o_carry, o_overflow, o_err
    );

    modport slave (
        input  i_valid, i_opcode, i_ope1, i_ope2,
        output o_result, o_valid, o_zero, o_carry, o_overflow, o_err
    );
endinterface

// File: rtl/alu_mod.sv
// Single-stage ALU: combinational arithmetic/logic/shift feeding one output register.
// Results and flags hold when no request is captured.
module alu_mod #(
    parameter int DATA_W = 8,
    parameter int OP_W   = 6
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    alu_mod_if.slave    bus
);
    typedef enum logic [OP_W-1:0] {
        OP_SRL = 6'b000010,
        OP_SRA = 6'b000011,
        OP_ADD = 6'b100000,
        OP_SUB = 6'b100010,
        OP_AND = 6'b100100,
        OP_OR  = 6'b100101,
        OP_XOR = 6'b100110,
        OP_NOR = 6'b100111
    } op_e;

    localparam logic [DATA_W-1:0] SH_LIM = DATA_W[DATA_W-1:0];
    localparam int unsigned MSB = DATA_W - 1;

    logic [DATA_W:0]   sum;
    logic [DATA_W:0]   diff;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] res_d;
    logic              carry_d;
    logic              ovf_d;
    logic              err_d;

    assign a    = bus.i_ope1;
    assign b    = bus.i_ope2;
    assign sum  = {1'b0, a} + {1'b0, b};
    // Top bit of the extended difference is set exactly when a < b unsigned.
    assign diff = {1'b0, a} - {1'b0, b};

    always_comb begin
        res_d   = '0;
        carry_d = 1'b0;
        ovf_d   = 1'b0;
        err_d   = 1'b0;
        case (bus.i_opcode)
            OP_ADD: begin
                res_d   = sum[DATA_W-1:0];
                carry_d = sum[DATA_W];
                ovf_d   = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
            end
            OP_SUB: begin
                res_d   = diff[DATA_W-1:0];
                carry_d = diff[DATA_W];
                ovf_d   = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);
            end
            OP_AND: res_d = a & b;
            OP_OR:  res_d = a | b;
            OP_XOR: res_d = a ^ b;
            OP_NOR: res_d = ~(a | b);
            OP_SRL: res_d = (b >= SH_LIM) ? '0 : (a >> b);
            OP_SRA: res_d = (b >= SH_LIM) ? {DATA_W{a[MSB]}} : DATA_W'($signed(a) >>> b);
            default: err_d = 1'b1;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            bus.o_result   <= '0;
            bus.o_valid    <= 1'b0;
            bus.o_zero     <= 1'b1;
            bus.o_carry    <= 1'b0;
            bus.o_overflow <= 1'b0;
            bus.o_err      <= 1'b0;
        end else begin
            bus.o_valid <= bus.i_valid;
            if (bus.i_valid) begin
                bus.o_result   <= res_d;
                bus.o_zero     <= (res_d == '0);
                bus.o_carry    <= carry_d;
                bus.o_overflow <= ovf_d;
                bus.o_err      <= err_d;
            end
        end
    end
endmodule

// File: tb/tb_alu_mod.sv
// Directed-vector bench for alu_mod with hand-computed expected results and flags.
module tb_alu_mod;
    localparam logic [5:0] ADD = 6'b100000, SUB = 6'b100010, AND_ = 6'b100100, OR_ = 6'b100101;
    localparam logic [5:0] XOR_ = 6'b100110, NOR_ = 6'b100111, SRL = 6'b000010, SRA = 6'b000011;

    logic i_clk;
    logic i_rst_n;
    int   n_chk;
    int   n_pass;

    alu_mod_if #(.DATA_W(8), .OP_W(6)) bus ();

    alu_mod #(.DATA_W(8), .OP_W(6)) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .bus     (bus.slave)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    // flags packed as {valid, zero, carry, overflow, err}
    function automatic logic [4:0] flags();
        return {bus.o_valid, bus.o_zero, bus.o_carry, bus.o_overflow, bus.o_err};
    endfunction

    task automatic op(input string tag, input logic [5:0] opc, input logic [7:0] a,
                      input logic [7:0] b, input logic [7:0] exp_r, input logic [4:0] exp_f);
        @(negedge i_clk);
        bus.i_valid  = 1'b1;
        bus.i_opcode = opc;
        bus.i_ope1   = a;
        bus.i_ope2   = b;
        @(posedge i_clk);
        #1;
        check({tag, ".res"}, 32'(bus.o_result), 32'(exp_r));
        check({tag, ".flg"}, 32'(flags()), 32'(exp_f));
    endtask

    initial begin
        n_chk = 0;
        n_pass = 0;
        i_rst_n      = 1'b0;
        bus.i_valid  = 1'b0;
        bus.i_opcode = '0;
        bus.i_ope1   = '0;
        bus.i_ope2   = '0;
        #12;
        check("rst.res", 32'(bus.o_result), 32'h0);
        check("rst.flg", 32'(flags()), 32'b01000);
        @(negedge i_clk);
        i_rst_n = 1'b1;

        // A=F1 B=F2 sweep
        op("f_add", ADD,  8'hF1, 8'hF2, 8'hE3, 5'b10100);
        op("f_sub", SUB,  8'hF1, 8'hF2, 8'hFF, 5'b10100);
        op("f_and", AND_, 8'hF1, 8'hF2, 8'hF0, 5'b10000);
        op("f_or",  OR_,  8'hF1, 8'hF2, 8'hF3, 5'b10000);
        op("f_xor", XOR_, 8'hF1, 8'hF2, 8'h03, 5'b10000);
        op("f_sra", SRA,  8'hF1, 8'hF2, 8'hFF, 5'b10000);
        op("f_srl", SRL,  8'hF1, 8'hF2, 8'h00, 5'b11000);
        op("f_nor", NOR_, 8'hF1, 8'hF2, 8'h0C, 5'b10000);
        // A=01 B=0F sweep
        op("s_add", ADD,  8'h01, 8'h0F, 8'h10, 5'b10000);
        op("s_sub", SUB,  8'h01, 8'h0F, 8'hF2, 5'b10100);
        op("s_and", AND_, 8'h01, 8'h0F, 8'h01, 5'b10000);
        op("s_or",  OR_,  8'h01, 8'h0F, 8'h0F, 5'b10000);
        op("s_xor", XOR_, 8'h01, 8'h0F, 8'h0E, 5'b10000);
        op("s_sra", SRA,  8'h01, 8'h0F, 8'h00, 5'b11000);
        op("s_srl", SRL,  8'h01, 8'h0F, 8'h00, 5'b11000);
        op("s_nor", NOR_, 8'h01, 8'h0F, 8'hF0, 5'b10000);
        // overflow, zero and shift boundaries
        op("ovf_add", ADD, 8'h7F, 8'h01, 8'h80, 5'b10010);
        op("ovf_sub", SUB, 8'h80, 8'h01, 8'h7F, 5'b10010);
        op("z_add",   ADD, 8'hFF, 8'h01, 8'h00, 5'b11100);
        op("sra3",    SRA, 8'h80, 8'h03, 8'hF0, 5'b10000);
        op("srl3",    SRL, 8'h80, 8'h03, 8'h10, 5'b10000);
        op("sra7",    SRA, 8'h80, 8'h07, 8'hFF, 5'b10000);
        op("srl8",    SRL, 8'hFF, 8'h08, 8'h00, 5'b11000);
        op("sra8p",   SRA, 8'h7F, 8'h08, 8'h00, 5'b11000);
        op("srl7",    SRL, 8'hFF, 8'h07, 8'h01, 5'b10000);
        op("sub_eq",  SUB, 8'h55, 8'h55, 8'h00, 5'b11000);
        // unsupported opcode
        op("err", 6'b000000, 8'hF1, 8'hF2, 8'h00, 5'b11001);
        op("err_clr", ADD, 8'h01, 8'h02, 8'h03, 5'b10000);

        // valid toggling 1,0,1: result and flags hold while idle
        op("tg1", SUB, 8'h01, 8'h0F, 8'hF2, 5'b10100);
        @(negedge i_clk);
        bus.i_valid  = 1'b0;
        bus.i_opcode = ADD;
        bus.i_ope1   = 8'h00;
        bus.i_ope2   = 8'h00;
        @(posedge i_clk);
        #1;
        check("tg0.res", 32'(bus.o_result), 32'hF2);
        check("tg0.flg", 32'(flags()), 32'b00100);
        op("tg2", XOR_, 8'hAA, 8'h0F, 8'hA5, 5'b10000);

        // asynchronous reset pulse between edges
        #2;
        bus.i_valid = 1'b0;
        i_rst_n = 1'b0;
        #1;
        check("arst.res", 32'(bus.o_result), 32'h0);
        check("arst.flg", 32'(flags()), 32'b01000);
        #1;
        i_rst_n = 1'b1;
        @(posedge i_clk);
        #1;
        check("post.res", 32'(bus.o_result), 32'h0);
        check("post.flg", 32'(flags()), 32'b01000);
        op("post_op", OR_, 8'h30, 8'h03, 8'h33, 5'b10000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running, expected finished");
        $fatal(1);
    end
endmodule
